// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter.
// FSM state encoding and watchdog counter width.
package uart_arb_pkg;

  localparam int TMO_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_WBUSY = 2'd2;
  localparam logic [1:0] S_WDONE = 2'd3;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side valid/ready bundle for uart_tx_arbiter.
// Two requesters share one accept vector.
interface uart_tx_arbiter_if;

  logic [1:0] req_valid;
  logic [7:0] req0_data;
  logic [7:0] req1_data;
  logic [1:0] req_ready;

  modport master (
    output req_valid,
    output req0_data,
    output req1_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req0_data,
    input  req1_data,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
// rr picks the winner only when both requesters are valid.
module rr_arbiter2 (
  input  logic [1:0] req_valid,
  input  logic       rr,
  output logic [1:0] gnt,
  output logic       gnt_idx,
  output logic       gnt_any
);

  logic both;
  logic only1;

  assign both    = &req_valid;
  assign only1   = req_valid[1] & ~req_valid[0];
  assign gnt_any = |req_valid;

  always_comb begin
    gnt_idx = 1'b0;
    unique case (1'b1)
      both:    gnt_idx = rr;
      only1:   gnt_idx = 1'b1;
      default: gnt_idx = 1'b0;
    endcase
  end

  always_comb begin
    gnt = 2'b00;
    if (gnt_any) begin
      gnt = gnt_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter between two requesters.
// Optional watchdog on the wait states: UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  req,
  input  logic              TX_STATUS,
  output logic [7:0]        TX_DATA,
  output logic              ctrl,
  output logic              busy,
  output logic              last_grant,
  input  logic              err_clr,
  output logic              timeout_err
);

  logic [1:0] state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       lg_q, lg_d;
  logic       rr_q, rr_d;

  logic [1:0] gnt;
  logic       gnt_idx;
  logic       gnt_any;
  logic       can_grant;
  logic       accept;
  logic       tmo;

  rr_arbiter2 u_rr (
    .req_valid (req.req_valid),
    .rr        (rr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_any   (gnt_any)
  );

  // reset gates the accept so nothing is offered while held in reset
  assign can_grant = (state_q == S_IDLE)
                   & TX_STATUS & reset & gnt_any;
  assign req.req_ready = can_grant ? gnt : 2'b00;
  assign accept = |(req.req_valid & req.req_ready);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    lg_d    = lg_q;
    rr_d    = rr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d  = gnt_idx ? req.req1_data
                            : req.req0_data;
          lg_d    = gnt_idx;
          rr_d    = ~gnt_idx;
          state_d = S_SEND;
        end
      end
      S_SEND:  state_d = S_WBUSY;
      S_WBUSY: if (!TX_STATUS) state_d = S_WDONE;
      S_WDONE: if (TX_STATUS) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (tmo) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      data_q  <= 8'h00;
      lg_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      lg_q    <= lg_d;
      rr_q    <= rr_d;
    end
  end

  assign TX_DATA    = data_q;
  assign ctrl       = (state_q == S_SEND);
  assign busy       = (state_q != S_IDLE);
  assign last_grant = lg_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LIM =
    TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic             err_q, err_d;
  logic             waiting;

  assign waiting = (state_q == S_WBUSY)
                 | (state_q == S_WDONE);
  assign cnt_nxt = cnt_q + 16'd1;

  always_comb begin
    cnt_d = cnt_q;
    tmo   = 1'b0;
    if (state_q == S_SEND) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_nxt;
      tmo   = (cnt_nxt == TMO_LIM);
    end
    // a timeout in the same cycle as a clear keeps the flag set
    err_d = tmo     ? 1'b1 :
            err_clr ? 1'b0 : err_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_cfg;

  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = ^{err_clr, TMO_W'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple UART model.
// Timeout checks follow UART_TX_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [7:0] d;
    logic       g;
  } exp_t;

  localparam int FRAME = 20;

  logic       clk;
  logic       reset;
  logic       TX_STATUS;
  logic [7:0] TX_DATA;
  logic       ctrl;
  logic       busy;
  logic       last_grant;
  logic       err_clr;
  logic       timeout_err;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.TIMEOUT_CYCLES(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (bus),
    .TX_STATUS   (TX_STATUS),
    .TX_DATA     (TX_DATA),
    .ctrl        (ctrl),
    .busy        (busy),
    .last_grant  (last_grant),
    .err_clr     (err_clr),
    .timeout_err (timeout_err)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_ctrl = 0;
  int   uart_cnt = 0;
  bit   hold_low = 0;
  bit   stuck = 0;
  exp_t sb[$];
  exp_t e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign TX_STATUS = (uart_cnt == 0) && !hold_low;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // UART model plus scoreboard pop on every load strobe
  always @(negedge clk) begin
    if (ctrl === 1'b1) begin
      n_ctrl++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        chk("sb_tx_data", 32'(TX_DATA), 32'(e.d));
        chk("sb_last_grant", 32'(last_grant), 32'(e.g));
      end
      if (!stuck) uart_cnt = FRAME;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_accept(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      #1;
      if (|(bus.req_valid & bus.req_ready)) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit ok;
    int target;
    reset = 1'b0;
    err_clr = 1'b0;
    bus.req_valid = 2'b00;
    bus.req0_data = 8'h00;
    bus.req1_data = 8'h00;

    // reset values, with a request already pending
    repeat (3) @(negedge clk);
    bus.req_valid = 2'b01;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ctrl", 32'(ctrl), 0);
    chk("rst_data", 32'(TX_DATA), 0);
    chk("rst_lg", 32'(last_grant), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    bus.req_valid = 2'b00;
    reset = 1'b1;
    @(negedge clk);

    // single byte from requester 0
    bus.req0_data = 8'hA5;
    bus.req_valid = 2'b01;
    sb.push_back('{d: 8'hA5, g: 1'b0});
    #1;
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    wait_accept(5, ok);
    chk("t1_accept", 32'(ok), 1);
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("t1_ctrl_hi", 32'(ctrl), 1);
    chk("t1_data", 32'(TX_DATA), 32'hA5);
    chk("t1_busy_hi", 32'(busy), 1);
    @(negedge clk);
    #1;
    chk("t1_ctrl_lo", 32'(ctrl), 0);
    wait_idle(100, ok);
    chk("t1_idle", 32'(ok), 1);
    chk("t1_busy_lo", 32'(busy), 0);

    // contention: alternate 0,1,0,1
    do_reset();
    bus.req0_data = 8'h11;
    bus.req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{d: (i % 2 == 0) ? 8'h11 : 8'h22,
                     g: (i % 2 == 1)});
    end
    bus.req_valid = 2'b11;
    target = n_ctrl + 4;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (n_ctrl >= target) break;
    end
    bus.req_valid = 2'b00;
    chk("t2_bytes", 32'(n_ctrl), 32'(target));
    wait_idle(100, ok);
    chk("t2_idle", 32'(ok), 1);

    // transmitter owned elsewhere: requests wait
    do_reset();
    hold_low = 1'b1;
    bus.req0_data = 8'h33;
    bus.req1_data = 8'h44;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 50; i++) begin
      #1;
      chk("t3_ready_low", 32'(bus.req_ready), 0);
      @(negedge clk);
    end
    hold_low = 1'b0;
    #1;
    chk("t3_ready", 32'(bus.req_ready), 32'h1);
    sb.push_back('{d: 8'h33, g: 1'b0});
    wait_accept(2, ok);
    chk("t3_accept", 32'(ok), 1);
    bus.req_valid = 2'b00;
    wait_idle(100, ok);
    chk("t3_idle", 32'(ok), 1);

    // reset pulsed during WAIT_DONE
    do_reset();
    bus.req0_data = 8'h5A;
    bus.req_valid = 2'b01;
    sb.push_back('{d: 8'h5A, g: 1'b0});
    wait_accept(5, ok);
    chk("t4_accept", 32'(ok), 1);
    bus.req_valid = 2'b00;
    repeat (6) @(negedge clk);
    #1;
    chk("t4_busy_hi", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("t4_ctrl", 32'(ctrl), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_data", 32'(TX_DATA), 0);
    chk("t4_lg", 32'(last_grant), 0);
    @(negedge clk);
    reset = 1'b1;
    bus.req0_data = 8'h66;
    bus.req1_data = 8'h77;
    bus.req_valid = 2'b11;
    sb.push_back('{d: 8'h66, g: 1'b0});
    #1;
    chk("t4_hold", 32'(bus.req_ready), 0);
    wait_accept(100, ok);
    chk("t4_accept2", 32'(ok), 1);
    bus.req_valid = 2'b00;
    wait_idle(100, ok);
    chk("t4_idle", 32'(ok), 1);

    // transmitter never goes busy after the load
    do_reset();
    stuck = 1'b1;
    bus.req0_data = 8'h99;
    bus.req_valid = 2'b01;
    sb.push_back('{d: 8'h99, g: 1'b0});
    wait_accept(5, ok);
    chk("t5_accept", 32'(ok), 1);
    bus.req_valid = 2'b00;
`ifdef UART_TX_ARB_TIMEOUT_EN
    wait_idle(40, ok);
    chk("t5_abort", 32'(ok), 1);
    chk("t5_terr_set", 32'(timeout_err), 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("t5_terr_clr", 32'(timeout_err), 0);
`else
    repeat (40) @(negedge clk);
    #1;
    chk("t5_terr_zero", 32'(timeout_err), 0);
    chk("t5_busy_hang", 32'(busy), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("t5_terr_clr", 32'(timeout_err), 0);
`endif
    stuck = 1'b0;
    do_reset();

    chk("sb_drain", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between two requesters: requester 0 is the CPU store path from the peripheral register block, and requester 1 is a hardware source such as RX echo or a debug dump. Arbitration is round-robin. The block drives the transmitter's `TX_DATA`/`ctrl` load interface and sequences each byte against `TX_STATUS`. A watchdog, included only when the build macro is defined, recovers from a transmitter that never completes. The block sits between the register block and the UART, inside the peripheral wrapper.

## Interface
- `TIMEOUT_CYCLES`, default 65535: maximum cycles allowed in either wait state before abort; range 1..65535.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester byte pending; must be held with its data until accepted.
- `req0_data`  in  8  byte from requester 0.
- `req1_data`  in  8  byte from requester 1.
- `req_ready`  out  2  one-hot accept. Combinational; the transfer happens when `req_valid[i] & req_ready[i]` is high at a clock edge.
- `TX_STATUS`  in  1  transmitter idle flag: 1 = idle, 0 = shifting.
- `TX_DATA`  out  8  byte presented to the transmitter; held until the next accept.
- `ctrl`  out  1  one-cycle load strobe to the transmitter.
- `busy`  out  1  high whenever the state is not IDLE.
- `last_grant`  out  1  index of the most recently accepted requester.
- `err_clr`  in  1  clears `timeout_err`.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
States:
- **IDLE:** if `TX_STATUS`=1 and any `req_valid` is set, grant one requester:
  - one valid: grant it;
  - both valid: grant index `rr`.
  - On the grant edge: latch the granted data into `TX_DATA`, set `last_grant`=g, set `rr`=~g, go to SEND.
- **SEND:** `ctrl`=1 for this cycle only. Go to WAIT_BUSY.
- **WAIT_BUSY:** wait for `TX_STATUS`=0, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `TX_STATUS`=1, then go to IDLE.

Accept rules:
- `req_ready` is nonzero only in IDLE with `TX_STATUS`=1 and `reset` deasserted; it is never two-hot.
- A requester dropping `req_valid` before it is accepted is legal; no transfer occurs.

Reset values: state IDLE, `TX_DATA`=8'h00, `ctrl`=0, `req_ready`=2'b00, `busy`=0, `last_grant`=0, `rr`=0, `timeout_err`=0.

Boundary behaviour:
- `TX_STATUS`=0 in IDLE (transmitter owned elsewhere): no grant; requests wait.
- Reset asserted mid-byte: return to IDLE immediately. A byte already loaded continues in the UART, but the next grant still requires `TX_STATUS`=1.
- `err_clr` and a timeout event in the same cycle: set wins.

## Timing
- Accept occurs in cycle 0; `TX_DATA` is valid and `ctrl`=1 in cycle 1; earliest WAIT_BUSY exit is in cycle 2.
- Minimum spacing between accepts is 4 cycles plus the UART frame time.
- `rr` updates on the accept edge, so back-to-back contention alternates 0,1,0,1.
- `busy` rises in cycle 1 and falls in the first cycle after WAIT_DONE exits.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - a 16-bit counter clears on entry to WAIT_BUSY and runs during WAIT_BUSY and WAIT_DONE;
  - when it reaches `TIMEOUT_CYCLES`, `timeout_err` is set and the state goes to IDLE on that edge.
- Macro undefined: no counter; `timeout_err` is tied to 0, `err_clr` is ignored, and the wait states can hang indefinitely.

## Structure
- Package `uart_arb_pkg`:
  - state encoding (IDLE=0, SEND=1, WAIT_BUSY=2, WAIT_DONE=3);
  - `TMO_W`=16.
- Sub-module `rr_arbiter2`: 2-way round-robin grant from `req_valid` and `rr`, producing a one-hot grant plus an index. It is purely combinational.
- The FSM, data latch and watchdog live in the top module.

## Test plan
- Single request, requester 0, data 8'hA5, `TX_STATUS`=1: `req_ready`=01 in cycle 0, `TX_DATA`=A5 and `ctrl`=1 in cycle 1 only; model drops `TX_STATUS` for 20 cycles then raises it; `busy` falls afterwards.
- Both requesters hold valid with 8'h11 and 8'h22 across 4 bytes: accepted order 11,22,11,22; `last_grant` sequence 0,1,0,1.
- `TX_STATUS` held 0 with requests pending for 50 cycles: `req_ready`=00 throughout; first accept in the cycle `TX_STATUS` rises.
- Reset pulsed low during WAIT_DONE: `ctrl`=0, `busy`=0 and `TX_DATA`=00 immediately; `rr` returns to 0.
- Macro defined with `TIMEOUT_CYCLES`=10 and `TX_STATUS` stuck at 1 after `ctrl`: `timeout_err` rises and the state returns to IDLE. Then assert `err_clr` alone: `timeout_err`=0 the next cycle.
- Macro undefined, same stimulus: `timeout_err` stays 0 and `busy` stays 1.
